// File: rtl/freq_pkg.sv
// Shared types and helpers for the gated frequency generator.
// Holds the default count width, the FSM state encoding and the clamp used on incoming N.
package freq_pkg;

  localparam int FREQ_CNT_W = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic logic [FREQ_CNT_W-1:0] clamp_n(
    input logic [FREQ_CNT_W-1:0] n,
    input logic [FREQ_CNT_W-1:0] lim
  );
    return (n > lim) ? lim : n;
  endfunction

endpackage

// File: rtl/freq_phase_acc.sv
// Bresenham phase accumulator: adds 2*N per step, wraps at GATE_CYCLES and raises
// a toggle strobe on each wrap so 2*N toggles land evenly across one window.
module freq_phase_acc #(
  parameter int          GATE_W      = 32,
  parameter int unsigned GATE_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              step,
  input  logic [GATE_W-1:0] n,
  output logic              toggle
);

  localparam logic [GATE_W:0] GC = (GATE_W+1)'(GATE_CYCLES);

  logic [GATE_W:0] acc;
  logic [GATE_W:0] sum;

  // acc < GC and 2*N <= GC, so sum never exceeds 2*GC and fits in GATE_W+1 bits
  assign sum    = acc + {n, 1'b0};
  assign toggle = step && (sum >= GC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (step) begin
      acc <= toggle ? (sum - GC) : sum;
    end
  end

endmodule

// File: rtl/freq_gen_gated.sv
// Gated stimulus generator: emits exactly N rising edges on signal_out per gate
// window, drives the matching period_out gate and reports edges emitted per window.
module freq_gen_gated
  import freq_pkg::*;
#(
  parameter int          CNT_W       = FREQ_CNT_W,
  parameter int          GATE_W      = 32,
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             period_out,
  output logic             signal_out,
  output logic [CNT_W-1:0] edges_last,
  output logic             window_done
);

  localparam logic [CNT_W-1:0] HALF = CNT_W'(GATE_CYCLES / 2);

  state_t            state, state_next;
  logic [GATE_W-1:0] cyc_cnt;
  logic              last_gate, last_gap, entry;
  logic              xfer, toggle;
  logic [CNT_W-1:0]  cfg_clamped;
  logic [GATE_W-1:0] n_shadow, n_active;
  logic [CNT_W-1:0]  edge_cnt;

  assign last_gate = (state == GATE) && (cyc_cnt == GATE_W'(GATE_CYCLES - 1));
  assign last_gap  = (state == GAP)  && (cyc_cnt == GATE_W'(GAP_CYCLES - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = GATE;
      GATE:    if (last_gate) state_next = GAP;
      GAP:     if (last_gap) state_next = enable ? GATE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign entry = (state != GATE) && (state_next == GATE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cyc_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state || state == IDLE) cyc_cnt <= '0;
      else                                      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

  // Handshake: a config word moves when cfg_valid && cfg_ready on a rising clk;
  // ready is held low for the whole window so active N cannot change mid-gate.
  assign cfg_ready   = (state != GATE);
  assign xfer        = cfg_valid && cfg_ready;
  assign cfg_clamped = CNT_W'(clamp_n(FREQ_CNT_W'(cfg_count), FREQ_CNT_W'(HALF)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_shadow <= '0;
      n_active <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= xfer && (cfg_count > HALF);
      if (xfer)  n_shadow <= GATE_W'(cfg_clamped);
      // A word arriving on the entry cycle is used by the window it opens
      if (entry) n_active <= xfer ? GATE_W'(cfg_clamped) : n_shadow;
    end
  end

  freq_phase_acc #(
    .GATE_W      (GATE_W),
    .GATE_CYCLES (GATE_CYCLES)
  ) u_phase_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (entry),
    .step   (state == GATE),
    .n      (n_active),
    .toggle (toggle)
  );

  // period_out is registered so it lines up with the registered toggle on signal_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_out  <= 1'b0;
      signal_out  <= 1'b0;
      edge_cnt    <= '0;
      edges_last  <= '0;
      window_done <= 1'b0;
    end else begin
      period_out  <= (state == GATE);
      window_done <= last_gate;
      if (entry) begin
        signal_out <= 1'b0;
        edge_cnt   <= '0;
      end else if (toggle) begin
        signal_out <= ~signal_out;
        if (!signal_out) edge_cnt <= edge_cnt + 1'b1;
      end
      // The final toggle of a window is always a fall, so edge_cnt is complete here
      if (last_gate) edges_last <= edge_cnt;
    end
  end

endmodule

// File: tb/tb_freq_gen_gated.sv
// Directed bench for freq_gen_gated with a 100-cycle gate and 4-cycle gap.
// Table of N values plus hand sequences for mid-gate config, enable drop and reset.
module tb_freq_gen_gated;

  localparam int CNT_W = 40;
  localparam int GC    = 100;
  localparam int GAP   = 4;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic [CNT_W-1:0] cfg_count;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_err;
  logic             period_out;
  logic             signal_out;
  logic [CNT_W-1:0] edges_last;
  logic             window_done;

  freq_gen_gated #(
    .CNT_W       (CNT_W),
    .GATE_W      (32),
    .GATE_CYCLES (GC),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .cfg_count   (cfg_count),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_err     (cfg_err),
    .period_out  (period_out),
    .signal_out  (signal_out),
    .edges_last  (edges_last),
    .window_done (window_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_comp = 0;
  int n_fail = 0;

  // scoreboard: expected rising-edge count per completed window, in order
  logic [CNT_W-1:0] exp_q[$];
  logic             mon_en = 1'b1;
  logic             prev_per = 1'b0;
  logic             prev_sig = 1'b0;
  logic             out_bad = 1'b0;
  int               hi_len = 0;
  int               rises = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_comp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // independent waveform monitor: gate length, edge count, signal low at gate fall
  always @(negedge clk) begin
    if (mon_en) begin
      if (period_out && !prev_per) begin
        hi_len = 0;
        rises  = 0;
      end
      if (period_out) begin
        hi_len++;
        if (signal_out && !prev_sig) rises++;
      end else if (signal_out) begin
        out_bad = 1'b1;
      end
      if (!period_out && prev_per) begin
        check("gate_len", 64'(hi_len), 64'(GC));
        check("sig_low_at_fall", 64'(prev_sig), 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_window", 64'd1, 64'd0);
        end else begin
          check("wave_rises", 64'(rises), 64'(exp_q.pop_front()));
        end
      end
    end
    prev_per = period_out;
    prev_sig = signal_out;
  end

  // driver tasks
  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (window_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("window_done_seen", 64'(seen), 64'd1);
  endtask

  task automatic send_cfg(input logic [CNT_W-1:0] n, input logic exp_err);
    @(negedge clk);
    cfg_count = n;
    cfg_valid = 1'b1;
    check("cfg_ready_idle", 64'(cfg_ready), 64'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("cfg_err", 64'(cfg_err), 64'(exp_err));
  endtask

  task automatic run_window(input logic [CNT_W-1:0] exp_edges);
    exp_q.push_back(exp_edges);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    check("cfg_err_one_cycle", 64'(cfg_err), 64'd0);
    wait_done(3 * GC);
    check("edges_last", 64'(edges_last), 64'(exp_edges));
    @(negedge clk);
    check("window_done_pulse", 64'(window_done), 64'd0);
    repeat (GAP + 2) @(negedge clk);
  endtask

  typedef struct {
    logic [CNT_W-1:0] n;
    logic [CNT_W-1:0] exp_edges;
    logic             exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cnt;
    bit ok;

    vecs[0] = '{n: 40'd5,  exp_edges: 40'd5,  exp_err: 1'b0};
    vecs[1] = '{n: 40'd0,  exp_edges: 40'd0,  exp_err: 1'b0};
    vecs[2] = '{n: 40'd50, exp_edges: 40'd50, exp_err: 1'b0};
    vecs[3] = '{n: 40'd60, exp_edges: 40'd50, exp_err: 1'b1};
    vecs[4] = '{n: 40'd1,  exp_edges: 40'd1,  exp_err: 1'b0};
    vecs[5] = '{n: 40'd49, exp_edges: 40'd49, exp_err: 1'b0};

    rst_n     = 1'b0;
    enable    = 1'b0;
    cfg_count = '0;
    cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period_out", 64'(period_out), 64'd0);
    check("rst_signal_out", 64'(signal_out), 64'd0);
    check("rst_edges_last", 64'(edges_last), 64'd0);
    check("rst_window_done", 64'(window_done), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // single windows over a range of N, including 0, the maximum and a clamp
    for (int v = 0; v < 6; v++) begin
      send_cfg(vecs[v].n, vecs[v].exp_err);
      run_window(vecs[v].exp_edges);
    end

    // config offered mid-gate is held off until GAP and used by the next window
    send_cfg(40'd5, 1'b0);
    exp_q.push_back(40'd5);
    exp_q.push_back(40'd7);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    cfg_count = 40'd7;
    cfg_valid = 1'b1;
    @(negedge clk);
    check("cfg_ready_in_gate", 64'(cfg_ready), 64'd0);
    ok = 1'b0;
    for (int i = 0; i < 3 * GC; i++) begin
      if (cfg_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("cfg_ready_in_gap", 64'(ok), 64'd1);
    check("held_cfg_done", 64'(window_done), 64'd1);
    check("held_cfg_old_n", 64'(edges_last), 64'd5);
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_done(3 * GC);
    check("held_cfg_new_n", 64'(edges_last), 64'd7);
    repeat (GAP + 2) @(negedge clk);

    // enable dropped at cycle 30 of the gate: window finishes, then back to IDLE
    send_cfg(40'd5, 1'b0);
    exp_q.push_back(40'd5);
    enable = 1'b1;
    repeat (31) @(negedge clk);
    enable = 1'b0;
    wait_done(3 * GC);
    check("enable_drop_edges", 64'(edges_last), 64'd5);
    cnt = 0;
    repeat (GAP + 20) begin
      @(negedge clk);
      if (period_out && !prev_per) cnt++;
    end
    check("enable_drop_idle", 64'(cnt), 64'd0);

    // reset at cycle 40 of the gate: outputs clear at once, no window report
    send_cfg(40'd9, 1'b0);
    mon_en = 1'b0;
    enable = 1'b1;
    repeat (41) @(negedge clk);
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check("midrst_period_out", 64'(period_out), 64'd0);
    check("midrst_signal_out", 64'(signal_out), 64'd0);
    check("midrst_edges_last", 64'(edges_last), 64'd0);
    check("midrst_cfg_ready", 64'(cfg_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (window_done) cnt++;
    end
    check("midrst_no_done", 64'(cnt), 64'd0);
    mon_en = 1'b1;

    // shadow N was cleared by reset, then a fresh window from acc=0
    run_window(40'd0);
    send_cfg(40'd5, 1'b0);
    run_window(40'd5);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("signal_low_outside_gate", 64'(out_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
